// File: rtl/tcb_htif_ctl.sv
// HTIF tohost/fromhost mailbox on the TCB bus: decodes exit and putchar commands,
// acknowledges through fromhost, buffers console bytes. Optional watchdog: HTIF_TIMEOUT_EN.
module tcb_htif_ctl #(
    parameter int unsigned DBW        = 32,
    parameter int unsigned ABW        = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ACK_DLY    = 4,
    parameter int unsigned TMO_CYC    = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tcb_vld_i,
    output logic             tcb_rdy_o,
    input  logic             tcb_wen_i,
    input  logic [ABW-1:0]   tcb_adr_i,
    input  logic [DBW/8-1:0] tcb_ben_i,
    input  logic [DBW-1:0]   tcb_wdt_i,
    output logic [DBW-1:0]   tcb_rdt_o,
    output logic             con_vld_o,
    input  logic             con_rdy_i,
    output logic [7:0]       con_dat_o,
    output logic             halt_o,
    output logic             pass_o,
    output logic [31:0]      exit_code_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (ACK_DLY > 1) ? $clog2(ACK_DLY) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_PUTC, S_ACK_WAIT, S_ACK, S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     tohost_q, fromhost_q;
    logic [DBW-1:0]  rdt_q;
    logic [31:0]     exit_code_q, exit_code_d;
    logic            halt_q, pass_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      con_dat_q, con_dat_d;
    logic            con_vld_q;

    logic            trn_c, wr_c, rd_c, commit_c, tmo_c, unused_c;
    logic            push_c, pop_c, full_c, ack_c, exit_c;
    logic [1:0]      reg_sel_c;
    logic [DBW-1:0]  lo_merged_c;

    function automatic logic [DBW-1:0] merge_be(input logic [DBW-1:0] old_w,
                                                input logic [DBW-1:0] new_w,
                                                input logic [DBW/8-1:0] be);
        for (int b = 0; b < DBW/8; b++) begin
            merge_be[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
    endfunction

    // Command words may only change while the mailbox is idle.
    assign tcb_rdy_o   = !(tcb_vld_i && tcb_wen_i && !tcb_adr_i[3] && (state_q != S_IDLE));
    assign trn_c       = tcb_vld_i && tcb_rdy_o;
    assign wr_c        = trn_c && tcb_wen_i;
    assign rd_c        = trn_c && !tcb_wen_i;
    assign reg_sel_c   = tcb_adr_i[3:2];
    assign lo_merged_c = merge_be(tohost_q[31:0], tcb_wdt_i, tcb_ben_i);
    assign commit_c    = wr_c && (reg_sel_c == 2'd0) && ({tohost_q[63:32], lo_merged_c} != 64'd0);

    assign full_c = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_c  = con_vld_q && con_rdy_i;

`ifdef HTIF_TIMEOUT_EN
    logic [31:0] wdt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    wdt_q <= '0;
        else if (commit_c)          wdt_q <= '0;
        else if (state_q != S_HALT) wdt_q <= wdt_q + 32'd1;
    end

    assign tmo_c    = (state_q != S_HALT) && (wdt_q == 32'(TMO_CYC - 1));
    assign unused_c = ^{tcb_adr_i[ABW-1:4], tcb_adr_i[1:0]};
`else
    assign tmo_c    = 1'b0;
    assign unused_c = ^{tcb_adr_i[ABW-1:4], tcb_adr_i[1:0], 32'(TMO_CYC)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (commit_c) state_d = S_DECODE;
            S_DECODE: begin
                if ((tohost_q[63:56] == 8'd0) && tohost_q[0])
                    state_d = S_HALT;
                else if ((tohost_q[63:56] == 8'd1) && (tohost_q[55:48] == 8'd1))
                    state_d = S_PUTC;
                else
                    state_d = S_ACK_WAIT;
            end
            S_PUTC:     if (push_c) state_d = S_ACK_WAIT;
            S_ACK_WAIT: if (cnt_q == CW'(ACK_DLY - 1)) state_d = S_ACK;
            S_ACK:      state_d = S_IDLE;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_IDLE;
        endcase
        if (tmo_c) state_d = S_HALT;
    end

    always_comb begin
        push_c      = (state_q == S_PUTC) && (!full_c || pop_c);
        ack_c       = (state_q == S_ACK);
        exit_c      = (state_q == S_DECODE) && (tohost_q[63:56] == 8'd0) && tohost_q[0];
        cnt_d       = (state_q == S_ACK_WAIT) ? cnt_q + CW'(1) : '0;
        exit_code_d = exit_code_q;
        if (exit_c) exit_code_d = {1'b0, tohost_q[31:1]};
        if (tmo_c)  exit_code_d = 32'hFFFF_FFFF;
    end

    // Mailbox registers, read port and status; ACK update takes priority over software.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tohost_q    <= '0;
            fromhost_q  <= '0;
            rdt_q       <= '0;
            exit_code_q <= '0;
            halt_q      <= 1'b0;
            pass_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            exit_code_q <= exit_code_d;
            halt_q      <= (state_d == S_HALT);
            pass_q      <= (state_d == S_HALT) && (exit_code_d == 32'd0);
            if (ack_c) begin
                tohost_q <= '0;
            end else if (wr_c && (reg_sel_c == 2'd0)) begin
                tohost_q[31:0] <= lo_merged_c;
            end else if (wr_c && (reg_sel_c == 2'd1)) begin
                tohost_q[63:32] <= merge_be(tohost_q[63:32], tcb_wdt_i, tcb_ben_i);
            end
            if (ack_c) begin
                fromhost_q <= {tohost_q[63:48], 48'd1};
            end else if (wr_c && (reg_sel_c == 2'd2)) begin
                fromhost_q[31:0] <= merge_be(fromhost_q[31:0], tcb_wdt_i, tcb_ben_i);
            end else if (wr_c && (reg_sel_c == 2'd3)) begin
                fromhost_q[63:32] <= merge_be(fromhost_q[63:32], tcb_wdt_i, tcb_ben_i);
            end
            if (rd_c) begin
                case (reg_sel_c)
                    2'd0:    rdt_q <= tohost_q[31:0];
                    2'd1:    rdt_q <= tohost_q[63:32];
                    2'd2:    rdt_q <= fromhost_q[31:0];
                    default: rdt_q <= fromhost_q[63:32];
                endcase
            end
        end
    end

    // Console FIFO: con_dat_q always holds the head entry after this cycle's push/pop.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + (AW+1)'(push_c);
        rd_ptr_d  = rd_ptr_q + (AW+1)'(pop_c);
        con_dat_d = con_dat_q;
        if (wr_ptr_d != rd_ptr_d) begin
            if (push_c && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0]))
                con_dat_d = tohost_q[7:0];
            else
                con_dat_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            con_vld_q <= 1'b0;
            con_dat_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            con_vld_q <= (wr_ptr_d != rd_ptr_d);
            con_dat_q <= con_dat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= tohost_q[7:0];
    end

    assign tcb_rdt_o   = rdt_q;
    assign con_vld_o   = con_vld_q;
    assign con_dat_o   = con_dat_q;
    assign halt_o      = halt_q;
    assign pass_o      = pass_q;
    assign exit_code_o = exit_code_q;

endmodule
